// File: rtl/xulie_piso_tx.sv
// Parallel-in/serial-out frame generator: shifts a WIDTH-bit word MSB-first onto
// Dout, each bit held BIT_CYCLES clocks. Define XULIE_PISO_PARITY_EN to append an even-parity bit.
module xulie_piso_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  output logic             Ready,
  output logic             Dout,
  output logic             Busy,
  output logic             Done
);

  localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
  localparam int BIT_W = $clog2(WIDTH) + 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef XULIE_PISO_PARITY_EN
    ,
    S_PAR
`endif
  } state_t;

  state_t           state_q, state_d;
  // The MSB goes straight to Dout on acceptance, so only the remaining bits are stored.
  logic [WIDTH-2:0] rest_q,  rest_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [CYC_W-1:0] cyc_q,   cyc_d;
  logic             dout_q,  dout_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
`ifdef XULIE_PISO_PARITY_EN
  logic             par_q,   par_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    rest_d  = rest_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    dout_d  = dout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef XULIE_PISO_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        dout_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (Load && ready_q) begin
          state_d = S_SHIFT;
          rest_d  = Data[WIDTH-2:0];
          dout_d  = Data[WIDTH-1];
          ready_d = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          cyc_d   = '0;
`ifdef XULIE_PISO_PARITY_EN
          par_d   = ^Data;
`endif
        end
      end

      S_SHIFT: begin
        if (cyc_q != CYC_LAST) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          cyc_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d  = bit_q + 1'b1;
            dout_d = rest_q[WIDTH-2];
            rest_d = rest_q << 1;
          end else begin
`ifdef XULIE_PISO_PARITY_EN
            state_d = S_PAR;
            dout_d  = par_q;
`else
            state_d = S_IDLE;
            dout_d  = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef XULIE_PISO_PARITY_EN
      S_PAR: begin
        if (cyc_q != CYC_LAST) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          cyc_d   = '0;
          state_d = S_IDLE;
          dout_d  = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        dout_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset aborts any frame in flight without a Done pulse and wins over Load.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state_q <= S_IDLE;
      rest_q  <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      dout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef XULIE_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rest_q  <= rest_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef XULIE_PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Dout  = dout_q;

endmodule

// File: tb/tb_xulie_piso_tx.sv
// Scoreboard bench for xulie_piso_tx: one instance at BIT_CYCLES=1, one at BIT_CYCLES=3.
// Expected Dout streams are queued at load time and popped by a negedge monitor.
module tb_xulie_piso_tx;

`ifdef XULIE_PISO_PARITY_EN
  localparam int PAR_N = 1;
`else
  localparam int PAR_N = 0;
`endif
  localparam int BC_A = 1;
  localparam int BC_B = 3;
  localparam int FL_A = (8 + PAR_N) * BC_A;
  localparam int FL_B = (8 + PAR_N) * BC_B;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       ready_a, dout_a, busy_a, done_a;
  logic       ready_b, dout_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit q_a[$];
  bit q_b[$];
  bit mon_en = 1'b0;
  bit det_en = 1'b0;
  logic [3:0] det_hist = '0;
  int det_hits = 0;
  bit exp_bit;

  always #5 Clk = ~Clk;

  xulie_piso_tx #(.WIDTH(8), .BIT_CYCLES(BC_A)) dut_a (
    .Clk(Clk), .Reset(Reset), .Load(load_a), .Data(data_a),
    .Ready(ready_a), .Dout(dout_a), .Busy(busy_a), .Done(done_a)
  );

  xulie_piso_tx #(.WIDTH(8), .BIT_CYCLES(BC_B)) dut_b (
    .Clk(Clk), .Reset(Reset), .Load(load_b), .Data(data_b),
    .Ready(ready_b), .Dout(dout_b), .Busy(busy_b), .Done(done_b)
  );

  // Monitor: every busy cycle consumes one expected serial bit; idle cycles must be low.
  always @(negedge Clk) begin
    if (mon_en) begin
      n_tests++;
      if (busy_a) begin
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_bit: Dout=%0b with empty scoreboard at %0t", dout_a, $time);
        end else begin
          exp_bit = q_a.pop_front();
          if (dout_a !== exp_bit) begin
            n_fail++;
            $display("FAIL a_dout: got %0b expected %0b at %0t", dout_a, exp_bit, $time);
          end
        end
      end else if (dout_a !== 1'b0) begin
        n_fail++;
        $display("FAIL a_idle_dout: got %0b expected 0 at %0t", dout_a, $time);
      end
      n_tests++;
      if (busy_a !== ~ready_a) begin
        n_fail++;
        $display("FAIL a_busy_ready: Busy=%0b Ready=%0b at %0t", busy_a, ready_a, $time);
      end

      n_tests++;
      if (busy_b) begin
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_bit: Dout=%0b with empty scoreboard at %0t", dout_b, $time);
        end else begin
          exp_bit = q_b.pop_front();
          if (dout_b !== exp_bit) begin
            n_fail++;
            $display("FAIL b_dout: got %0b expected %0b at %0t", dout_b, exp_bit, $time);
          end
        end
      end else if (dout_b !== 1'b0) begin
        n_fail++;
        $display("FAIL b_idle_dout: got %0b expected 0 at %0t", dout_b, $time);
      end
      n_tests++;
      if (busy_b !== ~ready_b) begin
        n_fail++;
        $display("FAIL b_busy_ready: Busy=%0b Ready=%0b at %0t", busy_b, ready_b, $time);
      end

      // Reference 0110 detector watching instance a's serial stream.
      det_hist = {det_hist[2:0], dout_a};
      if (det_en && det_hist == 4'b0110) det_hits++;
    end
  end

  // Drive a word (caller is 1 time unit after a rising edge, with Ready=1) and queue its bits.
  task automatic send(input bit use_b, input logic [7:0] d);
    int bc;
    bc = use_b ? BC_B : BC_A;
    for (int i = 7; i >= 0; i--)
      for (int c = 0; c < bc; c++)
        if (use_b) q_b.push_back(d[i]); else q_a.push_back(d[i]);
    for (int c = 0; c < PAR_N * bc; c++)
      if (use_b) q_b.push_back(^d); else q_a.push_back(^d);
    if (use_b) begin load_b = 1'b1; data_b = d; end
    else       begin load_a = 1'b1; data_a = d; end
    @(posedge Clk); #1;
    if (use_b) begin load_b = 1'b0; data_b = 8'($urandom); end
    else       begin load_a = 1'b0; data_a = 8'($urandom); end
  endtask

  // Counts edges until Done; n = -1 when the bound expires.
  task automatic wait_done(input bit use_b, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge Clk); #1;
      if (use_b ? done_b : done_a) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      mon_en = 1'b1;
      n_tests++;
      if ({ready_a, busy_a, done_a, dout_a} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_hold: {Ready,Busy,Done,Dout}=%b expected 1000", {ready_a, busy_a, done_a, dout_a});
      end
    end
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      n_tests++;
      if ({ready_a, busy_a, done_a, dout_a, ready_b, done_b} !== 6'b100010) begin
        n_fail++;
        $display("FAIL reset_idle: a={Ready,Busy,Done,Dout}=%b b={Ready,Done}=%b", {ready_a, busy_a, done_a, dout_a}, {ready_b, done_b});
      end
    end
  endtask

  task automatic test_basic_36;
    int n;
    det_hits = 0;
    det_en   = 1'b1;
    send(1'b0, 8'h36);
    wait_done(1'b0, n);
    n_tests++;
    if (n !== FL_A) begin
      n_fail++;
      $display("FAIL basic_done_latency: got %0d expected %0d", n, FL_A);
    end
    n_tests++;
    if ({ready_a, busy_a, dout_a} !== 3'b100 || q_a.size() != 0) begin
      n_fail++;
      $display("FAIL basic_done_state: {Ready,Busy,Dout}=%b left=%0d expected 100 left=0", {ready_a, busy_a, dout_a}, q_a.size());
    end
    @(posedge Clk); #1;
    n_tests++;
    if (done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: Done=%0b one cycle later expected 0", done_a);
    end
    det_en = 1'b0;
    n_tests++;
    if (det_hits != 2) begin
      n_fail++;
      $display("FAIL basic_detector_hits: got %0d expected 2", det_hits);
    end
  endtask

  task automatic test_bit_cycles;
    int n;
    send(1'b1, 8'hA5);
    wait_done(1'b1, n);
    n_tests++;
    if (n !== FL_B) begin
      n_fail++;
      $display("FAIL bc3_done_latency: got %0d expected %0d", n, FL_B);
    end
    n_tests++;
    if (ready_b !== 1'b1 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL bc3_done_state: Ready=%0b left=%0d expected 1 left=0", ready_b, q_b.size());
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_load_while_busy;
    int n;
    send(1'b0, 8'h0F);
    repeat (3) begin @(posedge Clk); #1; end
    load_a = 1'b1;
    data_a = 8'hFF;
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready_low: Ready=%0b expected 0", ready_a);
    end
    @(posedge Clk); #1;
    load_a = 1'b0;
    wait_done(1'b0, n);
    n_tests++;
    if (n < 0 || n + 4 != FL_A) begin
      n_fail++;
      $display("FAIL busy_done_latency: got %0d expected %0d", (n < 0) ? n : n + 4, FL_A);
    end
    repeat (4) begin @(posedge Clk); #1; end
    n_tests++;
    if (ready_a !== 1'b1 || q_a.size() != 0) begin
      n_fail++;
      $display("FAIL busy_not_queued: Ready=%0b left=%0d expected 1 left=0", ready_a, q_a.size());
    end
  endtask

  task automatic test_reset_abort;
    int n;
    bit saw_done;
    send(1'b0, 8'hC3);
    repeat (3) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    q_a.delete();
    n_tests++;
    if ({ready_a, busy_a, done_a, dout_a} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_reset_state: {Ready,Busy,Done,Dout}=%b expected 1000", {ready_a, busy_a, done_a, dout_a});
    end
    saw_done = 1'b0;
    for (int i = 0; i < FL_A + 2; i++) begin
      @(posedge Clk); #1;
      if (done_a) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: Done pulsed after abort, expected none");
    end
    send(1'b0, 8'h81);
    wait_done(1'b0, n);
    n_tests++;
    if (n !== FL_A || q_a.size() != 0) begin
      n_fail++;
      $display("FAIL abort_recover: latency=%0d left=%0d expected %0d left=0", n, q_a.size(), FL_A);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    send(1'b0, 8'h3C);
    wait_done(1'b0, n);
    n_tests++;
    if (n !== FL_A) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d expected %0d", n, FL_A);
    end
    send(1'b0, 8'h5A);
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: Ready=%0b expected 0", ready_a);
    end
    wait_done(1'b0, n);
    n_tests++;
    if (n !== FL_A || q_a.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_second_latency: latency=%0d left=%0d expected %0d left=0", n, q_a.size(), FL_A);
    end
  endtask

  task automatic test_parity;
    int n;
    send(1'b0, 8'h37);
    wait_done(1'b0, n);
    n_tests++;
    if (n !== FL_A || q_a.size() != 0) begin
      n_fail++;
      $display("FAIL parity_37: latency=%0d left=%0d expected %0d left=0", n, q_a.size(), FL_A);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic_36();
    test_bit_cycles();
    test_load_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_parity();
    repeat (2) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xulie_piso_tx.md
# xulie_piso_tx

Parallel-in/serial-out stimulus generator that sits directly upstream of the `0110` Moore sequence detector. It accepts a parallel word over a load/ready handshake and shifts it MSB-first onto a single serial line that drives the detector's `Din`. The serial line idles low between frames.

## Interface
- `WIDTH`, default 8: data word width in bits; must be ≥ 2.
- `BIT_CYCLES`, default 1: clock cycles each serial bit is held; must be ≥ 1.
- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  reset; synchronous, active-high, sampled on the rising `Clk` edge.
- `Load`  in  1  request to accept `Data`; effective only while `Ready`=1.
- `Data`  in  WIDTH  parallel word; sampled on the accepting edge only.
- `Ready`  out  1  block is idle and can accept a word.
- `Dout`  out  1  serial output, MSB first; connects to the detector's `Din`.
- `Busy`  out  1  a frame is being shifted out.
- `Done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Reset values, all registered: `Ready`=1, `Busy`=0, `Done`=0, `Dout`=0, shift register=0, bit counter=0, cycle counter=0. State is IDLE.
- States:
  - IDLE: `Dout`=0, `Ready`=1.
  - SHIFT: data bits.
  - PAR: parity bit; exists only with the macro.
- IDLE → SHIFT on an edge with `Load`=1 and `Ready`=1.
  - On that edge, `Data` is captured, `Dout` takes `Data[WIDTH-1]`, `Ready` goes 0, `Busy` goes 1, and both counters clear.
- In SHIFT, the cycle counter counts 0..BIT_CYCLES-1.
  - At terminal count with bits remaining: shift left, `Dout` takes the next bit, bit counter +1.
  - After bit index WIDTH-1 completes: go to PAR if parity is enabled, otherwise go to IDLE.
- PAR holds the parity bit for BIT_CYCLES cycles, then goes to IDLE.
- Entry into IDLE from SHIFT or PAR, on the same edge: `Dout`=0, `Ready`=1, `Busy`=0, `Done`=1 for exactly one cycle.
- `Load` while `Ready`=0 is ignored. It is not queued, and `Data` is not sampled.
- `Data` changes after acceptance have no effect on the frame in flight.
- Counter widths: cycle counter is $clog2(BIT_CYCLES)+1 bits; bit counter is $clog2(WIDTH)+1 bits. Neither counter wraps within a frame.
- Reset asserted mid-frame aborts the frame:
  - Next edge gives reset values.
  - No `Done` pulse is produced.
  - Reset has priority over `Load` on the same edge.

## Timing
- Accept edge k: first bit appears on `Dout` after edge k.
- Bit i is valid from edge k+i·BIT_CYCLES to edge k+(i+1)·BIT_CYCLES.
- Frame length is WIDTH·BIT_CYCLES cycles, plus BIT_CYCLES for parity.
- `Done` and `Ready` rise on edge k + frame length.
- Back-to-back frames: the earliest next accept is one cycle after `Ready` rises. This guarantees at least one idle `Dout`=0 cycle between frames, and the downstream detector sees that zero as a stream bit.
- `Busy` = ~`Ready` at all times.

## Configuration
- `XULIE_PISO_PARITY_EN`
  - Defined: after the data bits, one even-parity bit (XOR of the captured word) is held for BIT_CYCLES cycles in state PAR before `Done`.
  - Undefined: PAR state and parity logic are absent, and `Done` follows the last data bit.

## Test plan
- Reset held 3 cycles, then released with `Load`=0 for 5 cycles -> `Ready`=1, `Busy`=0, `Done`=0, `Dout`=0 throughout.
- WIDTH=8, BIT_CYCLES=1, `Data`=8'h36, `Load` 1 cycle -> `Dout` = 0,0,1,1,0,1,1,0 over 8 consecutive cycles, then `Done`=1 for 1 cycle with `Ready`=1. When chained to the detector, the detector flags the sequence twice.
- BIT_CYCLES=3, `Data`=8'hA5 -> each bit of 1,0,1,0,0,1,0,1 held for exactly 3 cycles; `Done` 24 cycles after accept.
- `Load` pulsed with `Data`=8'hFF while `Busy`=1 during an 8'h0F frame -> 8'h0F is transmitted unchanged and 8'hFF is never sent.
- Reset asserted after the 4th bit of 8'hC3 -> `Dout`=0 and `Ready`=1 on the next edge, no `Done`; a new `Load` of 8'h81 afterwards transmits cleanly.
- With `XULIE_PISO_PARITY_EN`:
  - 8'h36 -> parity bit 0 appended (9 bits).
  - 8'h37 -> parity bit 1 appended.
  - In both cases `Done` occurs 9 cycles after accept.
